// File: rtl/raster_ntri_if.sv
// Pixel-side bundle of the NTRI rasteriser: VGA counters, per-line setup vectors,
// shading controls, texture ROM handshake and the shaded pixel result.
interface raster_ntri_if #(
  parameter int NTRI     = 2,
  parameter int EW       = 20,
  parameter int BW       = 22,
  parameter int TEX_BITS = 7
);
  localparam int IW = (NTRI > 1) ? $clog2(NTRI) : 1;

  logic [9:0]            x;
  logic [9:0]            y;
  logic [NTRI*3*EW-1:0]  edge_init;
  logic [NTRI*3*EW-1:0]  edge_step;
  logic [NTRI*2*BW-1:0]  bar_init;
  logic [NTRI*2*BW-1:0]  bar_step;
  logic                  cull_en;
  logic [1:0]            mode;
  logic [NTRI*6-1:0]     tri_color;
  logic [5:0]            bg_color;
  logic                  texel;
  logic [TEX_BITS-1:0]   tex_u;
  logic [TEX_BITS-1:0]   tex_v;
  logic [5:0]            rgb;
  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic                  back_face;

  modport master (
    output x, y, edge_init, edge_step, bar_init, bar_step, cull_en, mode,
           tri_color, bg_color, texel,
    input  tex_u, tex_v, rgb, hit, hit_idx, back_face
  );

  modport slave (
    input  x, y, edge_init, edge_step, bar_init, bar_step, cull_en, mode,
           tri_color, bg_color, texel,
    output tex_u, tex_v, rgb, hit, hit_idx, back_face
  );
endinterface

// File: rtl/raster_ntri.sv
// Per-pixel rasteriser for NTRI triangles: steps edge functions and barycentrics along
// each VGA line, picks the lowest-index covering triangle and shades it to 6-bit rgb.
module raster_ntri #(
  parameter int NTRI     = 2,
  parameter int EW       = 20,
  parameter int BW       = 22,
  parameter int TEX_BITS = 7,
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input logic          clk,
  input logic          rst_n,
  raster_ntri_if.slave bus
);
  localparam int IW = (NTRI > 1) ? $clog2(NTRI) : 1;
  localparam int PW = $clog2(PIX_DIV);

  logic signed [EW-1:0] e_q [NTRI][3];
  logic signed [EW-1:0] e_d [NTRI][3];
  logic signed [BW-1:0] b_q [NTRI][2];
  logic signed [BW-1:0] b_d [NTRI][2];
  logic [TEX_BITS-1:0]  u_q [NTRI];
  logic [TEX_BITS-1:0]  u_d [NTRI];
  logic [TEX_BITS-1:0]  v_q [NTRI];
  logic [TEX_BITS-1:0]  v_d [NTRI];
  logic [PW-1:0]        phase_q, phase_d;
  logic [5:0]           rgb_q, rgb_d;
  logic                 hit_q, hit_d;
  logic [IW-1:0]        hit_idx_q, hit_idx_d;
  logic                 back_face_q, back_face_d;

  logic                 load_s, active_s;
  logic [NTRI-1:0]      front_s, back_s;
  logic                 sel_hit_s, sel_back_s;
  logic [IW-1:0]        sel_idx_s;
  logic [5:0]           color_s, shade_s;

  assign load_s   = (bus.x == 10'(H_TOTAL - 1)) &&
                    ((bus.y < 10'(V_ACTIVE)) || (bus.y == 10'(V_TOTAL - 1)));
  assign active_s = (bus.x < 10'(H_ACTIVE)) && (bus.y < 10'(V_ACTIVE));

  // Zero on any edge counts as outside for both windings.
  always_comb begin
    for (int t = 0; t < NTRI; t++) begin
      front_s[t] = e_q[t][0][EW-1] & e_q[t][1][EW-1] & e_q[t][2][EW-1];
      back_s[t]  = !e_q[t][0][EW-1] && (e_q[t][0] != '0) &&
                   !e_q[t][1][EW-1] && (e_q[t][1] != '0) &&
                   !e_q[t][2][EW-1] && (e_q[t][2] != '0);
    end
  end

  // Descending scan so the lowest covering index wins.
  always_comb begin
    sel_hit_s  = 1'b0;
    sel_idx_s  = '0;
    sel_back_s = 1'b0;
    for (int t = NTRI - 1; t >= 0; t--) begin
      if (front_s[t] || (back_s[t] && !bus.cull_en)) begin
        sel_hit_s  = 1'b1;
        sel_idx_s  = IW'(t);
        sel_back_s = !front_s[t];
      end else begin
        sel_hit_s  = sel_hit_s;
      end
    end
  end

  assign color_s = bus.tri_color[int'(hit_idx_q) * 6 +: 6];

  always_comb begin
    shade_s = 6'h00;
    if (!hit_q) begin
      shade_s = bus.bg_color;
    end else begin
      case (bus.mode)
        2'd0:    shade_s = bus.texel ? color_s : bus.bg_color;
        2'd1:    shade_s = bus.texel ? color_s : 6'h3F;
        2'd2:    shade_s = back_face_q ? ~color_s : color_s;
        default: shade_s = 6'h00;
      endcase
    end
  end

  // Load beats phase actions; pixel work only inside the active window.
  always_comb begin
    e_d         = e_q;
    b_d         = b_q;
    u_d         = u_q;
    v_d         = v_q;
    phase_d     = phase_q;
    rgb_d       = rgb_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    back_face_d = back_face_q;
    if (load_s) begin
      for (int t = 0; t < NTRI; t++) begin
        for (int k = 0; k < 3; k++) e_d[t][k] = bus.edge_init[(t*3+k)*EW +: EW];
        for (int j = 0; j < 2; j++) b_d[t][j] = bus.bar_init[(t*2+j)*BW +: BW];
      end
      phase_d = '0;
      rgb_d   = 6'h00;
    end else if (active_s) begin
      phase_d = (phase_q == PW'(PIX_DIV - 1)) ? '0 : phase_q + PW'(1);
      if (phase_q == '0) begin
        for (int t = 0; t < NTRI; t++) begin
          for (int j = 0; j < 2; j++) b_d[t][j] = b_q[t][j] + bus.bar_step[(t*2+j)*BW +: BW];
          u_d[t] = b_d[t][1][BW-3 -: TEX_BITS];
          v_d[t] = b_d[t][0][BW-3 -: TEX_BITS];
        end
        hit_d       = sel_hit_s;
        hit_idx_d   = sel_idx_s;
        back_face_d = sel_back_s;
      end else if (phase_q == PW'(PIX_DIV - 1)) begin
        rgb_d = shade_s;
        for (int t = 0; t < NTRI; t++) begin
          for (int k = 0; k < 3; k++) e_d[t][k] = e_q[t][k] + bus.edge_step[(t*3+k)*EW +: EW];
        end
      end else begin
        phase_d = phase_d;
      end
    end else begin
      rgb_d = 6'h00;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NTRI; t++) begin
        for (int k = 0; k < 3; k++) e_q[t][k] <= '0;
        for (int j = 0; j < 2; j++) b_q[t][j] <= '0;
        u_q[t] <= '0;
        v_q[t] <= '0;
      end
      phase_q     <= '0;
      rgb_q       <= 6'h00;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      back_face_q <= 1'b0;
    end else begin
      e_q         <= e_d;
      b_q         <= b_d;
      u_q         <= u_d;
      v_q         <= v_d;
      phase_q     <= phase_d;
      rgb_q       <= rgb_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      back_face_q <= back_face_d;
    end
  end

  assign bus.tex_u     = u_q[hit_idx_q];
  assign bus.tex_v     = v_q[hit_idx_q];
  assign bus.rgb       = rgb_q;
  assign bus.hit       = hit_q;
  assign bus.hit_idx   = hit_idx_q;
  assign bus.back_face = back_face_q;
endmodule

// File: tb/tb_raster_ntri.sv
// Directed bench for raster_ntri (NTRI=2, PIX_DIV=2): drives VGA counters one pixel at a
// time and checks coverage, priority, culling, stepping, texturing, blanking and reset.
module tb_raster_ntri;
  localparam int NTRI = 2, EW = 20, BW = 22, TB = 7, PD = 2;
  localparam logic [5:0] C0 = 6'h21, C1 = 6'h0C, BG = 6'h15;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  raster_ntri_if #(.NTRI(NTRI), .EW(EW), .BW(BW), .TEX_BITS(TB)) bus ();

  raster_ntri #(.NTRI(NTRI), .EW(EW), .BW(BW), .TEX_BITS(TB), .PIX_DIV(PD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pixel(input int px, input int py);
    bus.x = 10'(px);
    bus.y = 10'(py);
    repeat (PD) @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int t, input int e0, input int e1, input int e2,
                         input int s0, input int s1, input int s2);
    bus.edge_init[(t*3+0)*EW +: EW] = EW'(e0);
    bus.edge_init[(t*3+1)*EW +: EW] = EW'(e1);
    bus.edge_init[(t*3+2)*EW +: EW] = EW'(e2);
    bus.edge_step[(t*3+0)*EW +: EW] = EW'(s0);
    bus.edge_step[(t*3+1)*EW +: EW] = EW'(s1);
    bus.edge_step[(t*3+2)*EW +: EW] = EW'(s2);
  endtask

  task automatic set_bar(input int t, input int bz, input int by, input int sz, input int sy);
    bus.bar_init[(t*2+1)*BW +: BW] = BW'(bz);
    bus.bar_init[(t*2+0)*BW +: BW] = BW'(by);
    bus.bar_step[(t*2+1)*BW +: BW] = BW'(sz);
    bus.bar_step[(t*2+0)*BW +: BW] = BW'(sy);
  endtask

  task automatic test_reset();
    total++; if (bus.rgb !== 6'h00) begin bad++; $display("FAIL reset_rgb got=%h exp=00", bus.rgb); end
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
    total++; if (bus.hit_idx !== 1'b0) begin bad++; $display("FAIL reset_idx got=%b exp=0", bus.hit_idx); end
    total++; if (bus.back_face !== 1'b0) begin bad++; $display("FAIL reset_bf got=%b exp=0", bus.back_face); end
    total++; if (bus.tex_u !== 7'd0) begin bad++; $display("FAIL reset_tex_u got=%0d exp=0", bus.tex_u); end
    total++; if (bus.tex_v !== 7'd0) begin bad++; $display("FAIL reset_tex_v got=%0d exp=0", bus.tex_v); end
  endtask

  task automatic test_flat_cover();
    bus.mode = 2'd2; bus.cull_en = 1'b0;
    set_tri(0, -5, -5, -5, 0, 0, 0);
    set_tri(1, 0, 0, 0, 0, 0, 0);
    pixel(799, 10);
    for (int px = 0; px < 4; px++) begin
      pixel(px, 11);
      total++; if (bus.hit !== 1'b1) begin bad++; $display("FAIL flat_hit x=%0d got=%b exp=1", px, bus.hit); end
      total++; if (bus.hit_idx !== 1'b0) begin bad++; $display("FAIL flat_idx x=%0d got=%b exp=0", px, bus.hit_idx); end
      total++; if (bus.rgb !== C0) begin bad++; $display("FAIL flat_rgb x=%0d got=%h exp=%h", px, bus.rgb, C0); end
    end
  endtask

  task automatic test_priority();
    set_tri(0, -1, -1, -1, 0, 0, 0);
    set_tri(1, -1, -1, -1, 0, 0, 0);
    pixel(799, 11);
    pixel(0, 12);
    total++; if (bus.hit_idx !== 1'b0) begin bad++; $display("FAIL prio_both got=%b exp=0", bus.hit_idx); end
    set_tri(0, 0, -1, -1, 0, 0, 0);
    pixel(799, 12);
    pixel(0, 13);
    total++; if (bus.hit_idx !== 1'b1) begin bad++; $display("FAIL prio_t1 got=%b exp=1", bus.hit_idx); end
    total++; if (bus.rgb !== C1) begin bad++; $display("FAIL prio_rgb got=%h exp=%h", bus.rgb, C1); end
  endtask

  task automatic test_backface();
    set_tri(0, 3, 3, 3, 0, 0, 0);
    set_tri(1, 0, 0, 0, 0, 0, 0);
    pixel(799, 13);
    pixel(0, 14);
    total++; if (bus.hit !== 1'b1) begin bad++; $display("FAIL back_hit got=%b exp=1", bus.hit); end
    total++; if (bus.back_face !== 1'b1) begin bad++; $display("FAIL back_bf got=%b exp=1", bus.back_face); end
    total++; if (bus.rgb !== 6'h1E) begin bad++; $display("FAIL back_rgb got=%h exp=1e", bus.rgb); end
    bus.cull_en = 1'b1;
    pixel(1, 14);
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL cull_hit got=%b exp=0", bus.hit); end
    total++; if (bus.rgb !== BG) begin bad++; $display("FAIL cull_rgb got=%h exp=%h", bus.rgb, BG); end
    bus.cull_en = 1'b0;
  endtask

  task automatic test_edge_step();
    set_tri(0, -1, -1, -1, 1, 0, 0);
    pixel(799, 14);
    pixel(0, 15);
    total++; if (bus.hit !== 1'b1) begin bad++; $display("FAIL step_px0 got=%b exp=1", bus.hit); end
    pixel(1, 15);
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL step_px1 got=%b exp=0", bus.hit); end
    total++; if (bus.rgb !== BG) begin bad++; $display("FAIL step_px1_rgb got=%h exp=%h", bus.rgb, BG); end
    pixel(799, 15);
    pixel(0, 16);
    total++; if (bus.hit !== 1'b1) begin bad++; $display("FAIL step_reload got=%b exp=1", bus.hit); end
  endtask

  task automatic test_texture();
    set_tri(0, -5, -5, -5, 0, 0, 0);
    set_bar(0, 32'h40000, 32'h20000, 0, 0);
    bus.mode = 2'd0; bus.texel = 1'b0;
    pixel(799, 16);
    pixel(0, 17);
    total++; if (bus.tex_u !== 7'd32) begin bad++; $display("FAIL tex_u got=%0d exp=32", bus.tex_u); end
    total++; if (bus.tex_v !== 7'd16) begin bad++; $display("FAIL tex_v got=%0d exp=16", bus.tex_v); end
    total++; if (bus.rgb !== BG) begin bad++; $display("FAIL tex0_rgb got=%h exp=%h", bus.rgb, BG); end
    bus.texel = 1'b1;
    pixel(1, 17);
    total++; if (bus.rgb !== C0) begin bad++; $display("FAIL tex1_rgb got=%h exp=%h", bus.rgb, C0); end
    bus.mode = 2'd1; bus.texel = 1'b0;
    pixel(2, 17);
    total++; if (bus.rgb !== 6'h3F) begin bad++; $display("FAIL white_rgb got=%h exp=3f", bus.rgb); end
    bus.mode = 2'd3;
    pixel(3, 17);
    total++; if (bus.rgb !== 6'h00) begin bad++; $display("FAIL black_rgb got=%h exp=00", bus.rgb); end
    // One texel LSB per pixel along u.
    set_bar(0, 0, 0, 32'h2000, 0);
    bus.mode = 2'd2;
    pixel(799, 17);
    pixel(0, 18);
    total++; if (bus.tex_u !== 7'd1) begin bad++; $display("FAIL tex_step0 got=%0d exp=1", bus.tex_u); end
    pixel(1, 18);
    total++; if (bus.tex_u !== 7'd2) begin bad++; $display("FAIL tex_step1 got=%0d exp=2", bus.tex_u); end
    set_bar(0, 0, 0, 0, 0);
  endtask

  task automatic test_blank_load();
    pixel(700, 18);
    total++; if (bus.rgb !== 6'h00) begin bad++; $display("FAIL hblank_rgb got=%h exp=00", bus.rgb); end
    set_tri(0, 0, 0, 0, 0, 0, 0);
    pixel(799, 18);
    set_tri(0, -5, -5, -5, 0, 0, 0);
    pixel(799, 500);
    pixel(0, 19);
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL vblank_noload got=%b exp=0", bus.hit); end
    pixel(799, 524);
    pixel(0, 0);
    total++; if (bus.hit !== 1'b1) begin bad++; $display("FAIL frame_load got=%b exp=1", bus.hit); end
  endtask

  task automatic test_reset_midline();
    pixel(799, 20);
    for (int px = 0; px < 300; px++) pixel(px, 21);
    total++; if (bus.rgb !== C0) begin bad++; $display("FAIL pre_rst_rgb got=%h exp=%h", bus.rgb, C0); end
    bus.x = 10'd300;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.rgb !== 6'h00) begin bad++; $display("FAIL midrst_rgb got=%h exp=00", bus.rgb); end
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL midrst_hit got=%b exp=0", bus.hit); end
    @(negedge clk);
    rst_n = 1'b1;
    pixel(301, 21);
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL postrst_hit got=%b exp=0", bus.hit); end
    pixel(799, 21);
    pixel(0, 22);
    total++; if (bus.hit !== 1'b1) begin bad++; $display("FAIL nextline_hit got=%b exp=1", bus.hit); end
    total++; if (bus.rgb !== C0) begin bad++; $display("FAIL nextline_rgb got=%h exp=%h", bus.rgb, C0); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.x = 10'd0; bus.y = 10'd0;
    bus.edge_init = '0; bus.edge_step = '0;
    bus.bar_init = '0; bus.bar_step = '0;
    bus.cull_en = 1'b0; bus.mode = 2'd2;
    bus.tri_color = {C1, C0}; bus.bg_color = BG;
    bus.texel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_flat_cover();
    test_priority();
    test_backface();
    test_edge_step();
    test_texture();
    test_blank_load();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
